paicore_hs_loop_fifo: RTL and testbench

//  Elastic loop-back stage between the PAICORE send path's 32-bit request/acknowledge output and the

---
 rtl/paicore_hs_pkg.sv | 19 +
 rtl/paicore_sync_fifo.sv | 45 ++++
 rtl/paicore_hs_loop_fifo.sv | 129 ++++++++++++
 tb/tb_paicore_hs_loop_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/paicore_hs_pkg.sv
// Shared types for the PAICORE handshake loop-back: FSM state encodings and the word width.
// Pure declarations; no latency or backpressure of its own.
package paicore_hs_pkg;

    localparam int PAICORE_HS_W = 32;

    typedef enum logic [1:0] {
        IN_SYNC,
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } out_state_t;

endpackage

// File: rtl/paicore_sync_fifo.sv
// Register-array FIFO with wrapping pointers and an occupancy count; head word visible combinationally.
// Push/pop take effect at the clock edge; caller must not push when full or pop when empty.
module paicore_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic [ADDR_W:0]   level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; only entries below the level are ever read out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/paicore_hs_loop_fifo.sv
// Loop-back of a 4-phase request/ack word stream through a FIFO, with counters and an ack timeout.
// Capture edge N gives in_ack after N and out_req after N+1; a full FIFO holds in_ack low until space frees.
module paicore_hs_loop_fifo
    import paicore_hs_pkg::*;
#(
    parameter int DATA_W = PAICORE_HS_W,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int ACK_TO = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              in_req,
    input  logic [DATA_W-1:0] in_din,
    output logic              in_ack,
    output logic              out_req,
    output logic [DATA_W-1:0] out_dout,
    input  logic              out_ack,
    output logic [ADDR_W:0]   o_level,
    output logic [31:0]       o_in_cnt,
    output logic [31:0]       o_out_cnt,
    output logic              o_err_timeout
);

    localparam int TMR_W = $clog2(ACK_TO + 1);
    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(ACK_TO);
    localparam logic [TMR_W-1:0] TO_PRE   = TMR_W'(ACK_TO - 1);

    in_state_t         in_state;
    out_state_t        out_state;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_dat;
    logic [ADDR_W:0]   level;
    logic [31:0]       in_cnt;
    logic [31:0]       out_cnt;
    logic [TMR_W-1:0]  timer;

    assign push = (in_state == IN_IDLE) && in_req && (level != FULL_LVL) && !i_clr;
    assign pop  = (out_state == OUT_REQ) && out_ack && !i_clr;

    paicore_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (i_clr),
        .push     (push),
        .wr_dat   (in_din),
        .pop      (pop),
        .head_dat (head_dat),
        .level    (level)
    );

    // IN_SYNC keeps a request that straddles reset/clr from being taken as a new word.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            in_state <= IN_SYNC;
            in_ack   <= 1'b0;
            in_cnt   <= '0;
        end else begin
            case (in_state)
                IN_SYNC: begin
                    if (!in_req) in_state <= IN_IDLE;
                end
                IN_IDLE: begin
                    if (push) begin
                        in_ack   <= 1'b1;
                        in_cnt   <= in_cnt + 32'd1;
                        in_state <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!in_req) begin
                        in_ack   <= 1'b0;
                        in_state <= IN_IDLE;
                    end
                end
                default: in_state <= IN_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            out_state     <= OUT_IDLE;
            out_req       <= 1'b0;
            out_dout      <= '0;
            out_cnt       <= '0;
            timer         <= '0;
            o_err_timeout <= 1'b0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (level != '0) begin
                        out_dout  <= head_dat;
                        out_req   <= 1'b1;
                        timer     <= '0;
                        out_state <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (out_ack) begin
                        out_req   <= 1'b0;
                        out_cnt   <= out_cnt + 32'd1;
                        out_state <= OUT_WAIT;
                    end else if (timer != TO_LAST) begin
                        // Saturates at ACK_TO; the word stays offered after the flag sets.
                        timer <= timer + TMR_W'(1);
                        if (timer == TO_PRE) o_err_timeout <= 1'b1;
                    end
                end
                OUT_WAIT: begin
                    if (!out_ack) out_state <= OUT_IDLE;
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

    assign o_level   = level;
    assign o_in_cnt  = in_cnt;
    assign o_out_cnt = out_cnt;

endmodule

// File: tb/tb_paicore_hs_loop_fifo.sv
// Scoreboard bench: upstream driver queues accepted words, a downstream monitor checks them in order.
module tb_paicore_hs_loop_fifo;

    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clr;
    logic        in_req;
    logic [31:0] in_din;
    logic        in_ack;
    logic        out_req;
    logic [31:0] out_dout;
    logic        out_ack;
    logic [AW:0] o_level;
    logic [31:0] o_in_cnt;
    logic [31:0] o_out_cnt;
    logic        o_err_timeout;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_in = 0;
    logic [31:0] model_out = 0;
    bit          mon_auto = 1'b0;
    int          ack_max = 0;
    bit          track = 1'b0;
    int          max_lvl = 0;
    bit          seen = 1'b0;
    int          dly = 0;

    always #5 clk = ~clk;

    paicore_hs_loop_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (i_clr),
        .in_req        (in_req),
        .in_din        (in_din),
        .in_ack        (in_ack),
        .out_req       (out_req),
        .out_dout      (out_dout),
        .out_ack       (out_ack),
        .o_level       (o_level),
        .o_in_cnt      (o_in_cnt),
        .o_out_cnt     (o_out_cnt),
        .o_err_timeout (o_err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ack"},   32'(in_ack),        32'd0);
        check({tag, "_out_req"},  32'(out_req),       32'd0);
        check({tag, "_out_dout"}, out_dout,           32'd0);
        check({tag, "_level"},    32'(o_level),       32'd0);
        check({tag, "_in_cnt"},   o_in_cnt,           32'd0);
        check({tag, "_out_cnt"},  o_out_cnt,          32'd0);
        check({tag, "_err"},      32'(o_err_timeout), 32'd0);
    endtask

    // Downstream model: each rising out_req must carry the oldest outstanding word.
    initial begin
        out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (track && int'(o_level) > max_lvl) max_lvl = int'(o_level);
            if (out_req && !seen) begin
                seen = 1'b1;
                dly  = (ack_max > 0) ? int'($urandom_range(0, ack_max)) : 0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL out_word unexpected act=%h exp=none", out_dout);
                end else begin
                    check("out_word", out_dout, exp_q.pop_front());
                end
            end
            if (out_req && !out_ack && mon_auto) begin
                if (dly == 0) out_ack = 1'b1;
                else dly--;
            end
            if (!out_req) begin
                if (seen && out_ack) model_out++;
                seen    = 1'b0;
                out_ack = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [31:0] d);
        int k;
        in_din = d;
        in_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ack && k < 2000);
        check("push_ack", 32'(in_ack), 32'd1);
        if (!in_ack) begin
            in_req = 1'b0;
            return;
        end
        exp_q.push_back(d);
        model_in++;
        in_req = 1'b0;
        in_din = $urandom;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (in_ack && k < 100);
        check("ack_fall", 32'(in_ack), 32'd0);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || o_level != '0 || out_req || out_ack) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drained"}, 32'(k < 5000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr(input string tag);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        exp_q.delete();
        model_in  = 0;
        model_out = 0;
        check_idle(tag);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst    = 1'b1;
        i_clr  = 1'b0;
        in_req = 1'b0;
        in_din = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single word with exact latency
        mon_auto = 1'b1;
        ack_max  = 0;
        in_din   = 32'hA5A5_0001;
        in_req   = 1'b1;
        @(negedge clk);
        check("t1_in_ack", 32'(in_ack), 32'd1);
        check("t1_out_req_early", 32'(out_req), 32'd0);
        exp_q.push_back(32'hA5A5_0001);
        model_in++;
        in_req = 1'b0;
        @(negedge clk);
        check("t1_out_req", 32'(out_req), 32'd1);
        check("t1_out_dout", out_dout, 32'hA5A5_0001);
        drain("t1");
        check("t1_in_cnt", o_in_cnt, 32'd1);
        check("t1_out_cnt", o_out_cnt, 32'd1);
        check("t1_level", 32'(o_level), 32'd0);

        // Backpressure: fill to 64, word 64 must wait
        mon_auto = 1'b0;
        for (int i = 0; i < 64; i++) push_word(32'(i));
        in_din = 32'd64;
        in_req = 1'b1;
        repeat (8) @(negedge clk);
        check("t2_full_no_ack", 32'(in_ack), 32'd0);
        check("t2_level_full", 32'(o_level), 32'd64);
        mon_auto = 1'b1;
        ack_max  = 3;
        k = 0;
        while (!in_ack && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t2_late_ack", 32'(in_ack), 32'd1);
        if (in_ack) begin
            exp_q.push_back(32'd64);
            model_in++;
        end
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        drain("t2");
        check("t2_in_cnt", o_in_cnt, model_in);
        check("t2_out_cnt", o_out_cnt, model_out);
        check("t2_total", model_out, 32'd66);

        // Streaming with a prompt downstream
        pulse_clr("clr0");
        ack_max = 0;
        max_lvl = 0;
        track   = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(1, 2)) @(negedge clk);
            push_word($urandom);
        end
        drain("t3");
        track = 1'b0;
        check("t3_in_cnt", o_in_cnt, 32'd1000);
        check("t3_out_cnt", o_out_cnt, 32'd1000);
        check("t3_max_level_le2", 32'(max_lvl <= 2), 32'd1);

        // Ack timeout
        mon_auto = 1'b0;
        push_word(32'hDEAD_BEEF);
        check("t4_out_req", 32'(out_req), 32'd1);
        repeat (1020) @(negedge clk);
        check("t4_err_early", 32'(o_err_timeout), 32'd0);
        repeat (10) @(negedge clk);
        check("t4_err_set", 32'(o_err_timeout), 32'd1);
        check("t4_out_req_held", 32'(out_req), 32'd1);
        mon_auto = 1'b1;
        drain("t4");
        check("t4_err_sticky", 32'(o_err_timeout), 32'd1);
        check("t4_out_cnt", o_out_cnt, model_out);
        pulse_clr("clr1");

        // Reset in the middle of traffic
        mon_auto = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h5000 + 32'(i));
        repeat (2) @(negedge clk);
        check("t5_out_req", 32'(out_req), 32'd1);
        check("t5_level", 32'(o_level), 32'd4);
        rst    = 1'b1;
        in_din = 32'h7777_0000;
        in_req = 1'b1;
        @(negedge clk);
        check_idle("t5_rst");
        exp_q.delete();
        model_in  = 0;
        model_out = 0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_held_req_ignored", 32'(in_ack), 32'd0);
        check("t5_level_after", 32'(o_level), 32'd0);
        check("t5_in_cnt_after", o_in_cnt, 32'd0);
        in_req = 1'b0;
        @(negedge clk);
        mon_auto = 1'b1;
        push_word(32'h7777_0001);
        drain("t5");
        check("t5_in_cnt", o_in_cnt, 32'd1);
        check("t5_out_cnt", o_out_cnt, 32'd1);

        // Counter wrap
        force dut.in_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.in_cnt;
        @(negedge clk);
        check("t6_preset", o_in_cnt, 32'hFFFF_FFFF);
        model_in = 32'hFFFF_FFFF;
        push_word(32'hCAFE_F00D);
        check("t6_wrap", o_in_cnt, 32'd0);
        check("t6_model", o_in_cnt, model_in);
        drain("t6");
        check("t6_out_cnt", o_out_cnt, model_out);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
